// File: rtl/img_pkg.sv
// Shared types and constants for the 3x3 window generator.
// Tap indices number the window row-major from p00 (top-left) to p22 (bottom-right).
package img_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int WIN_W     = 9 * DEF_PIX_W;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int P00 = 0;
    localparam int P01 = 1;
    localparam int P02 = 2;
    localparam int P10 = 3;
    localparam int P11 = 4;
    localparam int P12 = 5;
    localparam int P20 = 6;
    localparam int P21 = 7;
    localparam int P22 = 8;

    // p00 occupies the most significant pixel slot of the packed window.
    function automatic int tap_lsb(input int idx, input int pix_w);
        return (8 - idx) * pix_w;
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel stream in, packed 3x3 window out; no backpressure in either direction.
interface window_3x3_gen_if
    import img_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
);
    logic               in_en;
    logic [PIX_W-1:0]   pixel_in;
    logic [9*PIX_W-1:0] win_out;
    logic               win_valid;
    logic               frame_done;

    modport master (
        output in_en,
        output pixel_in,
        input  win_out,
        input  win_valid,
        input  frame_done
    );

    modport slave (
        input  in_en,
        input  pixel_in,
        output win_out,
        output win_valid,
        output frame_done
    );
endinterface

// File: rtl/line_buffer.sv
// One-line delay: circular RAM read and written at the same wrapping address.
// dout shows the sample written DEPTH enabled cycles ago.
module line_buffer #(
    parameter int DEPTH = 128,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

    // Contents need no reset: stale samples only ever land in masked taps.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    assign dout = mem[ptr];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to zero-padded 3x3 neighbourhoods, one window per input pixel.
//   state  | meaning
//   FILL   | priming line buffers, no output until pixel (1,1) arrives
//   STREAM | each accepted pixel yields one window next cycle
//   FLUSH  | injecting IMG_W+1 zero pixels to emit the last row, input dropped
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic            clk,
    input  logic            rst_n,
    window_3x3_gen_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = $clog2(IMG_W + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(IMG_W);

    state_t state, state_nxt;

    logic [RW-1:0]      in_row, out_row;
    logic [CW-1:0]      in_col, out_col;
    logic [FW-1:0]      flush_cnt;
    logic               accept, shift, emit, frame_last;
    logic               fill_done, last_in, flush_tc;
    logic [PIX_W-1:0]   pix, lb0_dout, lb1_dout;
    logic [PIX_W-1:0]   row0 [2];
    logic [PIX_W-1:0]   row1 [2];
    logic [PIX_W-1:0]   row2 [2];
    logic [PIX_W-1:0]   tap  [9];
    logic               m_top, m_bot, m_left, m_right;
    logic [9*PIX_W-1:0] win_nxt;

    always_comb begin
        accept    = bus.in_en && (state != FLUSH);
        shift     = accept || (state == FLUSH);
        pix       = (state == FLUSH) ? '0 : bus.pixel_in;
        fill_done = (in_row == RW'(1)) && (in_col == CW'(1));
        last_in   = (in_row == ROW_LAST) && (in_col == COL_LAST);
        flush_tc  = (flush_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        emit       = 1'b0;
        frame_last = 1'b0;
        case (state)
            FILL: begin
                if (accept && fill_done) begin
                    emit      = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    emit = 1'b1;
                    if (last_in) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                emit = 1'b1;
                if (flush_tc) begin
                    frame_last = 1'b1;
                    state_nxt  = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_row    <= '0;
            in_col    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            flush_cnt <= '0;
        end else begin
            if (accept) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end
            if (emit) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end
            if (state == STREAM && state_nxt == FLUSH) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == FLUSH && !flush_tc) begin
                flush_cnt <= flush_cnt - FW'(1);
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift),
        .din   (pix),
        .dout  (lb0_dout)
    );

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift),
        .din   (lb0_dout),
        .dout  (lb1_dout)
    );

    // Two registered columns per row; the third (newest) column comes straight
    // from the incoming pixel and line-buffer outputs so the window is complete
    // in the same cycle the triggering pixel is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row0 <= '{default: '0};
            row1 <= '{default: '0};
            row2 <= '{default: '0};
        end else if (shift) begin
            row0[0] <= row0[1];
            row0[1] <= lb1_dout;
            row1[0] <= row1[1];
            row1[1] <= lb0_dout;
            row2[0] <= row2[1];
            row2[1] <= pix;
        end
    end

    always_comb begin
        tap[P00] = row0[0];
        tap[P01] = row0[1];
        tap[P02] = lb1_dout;
        tap[P10] = row1[0];
        tap[P11] = row1[1];
        tap[P12] = lb0_dout;
        tap[P20] = row2[0];
        tap[P21] = row2[1];
        tap[P22] = pix;
    end

    // The right column wraps onto the next line's first pixels; masking hides them.
    always_comb begin
        m_top   = (out_row == '0);
        m_bot   = (out_row == ROW_LAST);
        m_left  = (out_col == '0);
        m_right = (out_col == COL_LAST);
        win_nxt = '0;
        for (int i = 0; i < 9; i++) begin
            if (!((i / 3 == 0 && m_top) || (i / 3 == 2 && m_bot) ||
                  (i % 3 == 0 && m_left) || (i % 3 == 2 && m_right))) begin
                win_nxt[tap_lsb(i, PIX_W) +: PIX_W] = tap[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.win_out    <= '0;
            bus.win_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.win_valid  <= emit;
            bus.frame_done <= frame_last;
            if (emit) begin
                bus.win_out <= win_nxt;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench: a 4x4 instance for pattern/stall/reset cases, a 128x128 one for full frames.
module tb_window_3x3_gen;

    localparam int PW = 8;
    localparam int WW = 9 * PW;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 128;
    localparam int LH = 128;

    typedef struct {
        logic [WW-1:0] win;
        logic          fd;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_s_n;
    logic rst_l_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   s_vld = 0;
    int   s_fd = 0;
    int   l_vld = 0;
    int   l_fd = 0;
    exp_t sq[$];
    exp_t lq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    window_3x3_gen_if #(.PIX_W(PW)) bus_s ();
    window_3x3_gen_if #(.PIX_W(PW)) bus_l ();

    window_3x3_gen #(.PIX_W(PW), .IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk   (clk),
        .rst_n (rst_s_n),
        .bus   (bus_s)
    );

    window_3x3_gen #(.PIX_W(PW), .IMG_W(LW), .IMG_H(LH)) dut_l (
        .clk   (clk),
        .rst_n (rst_l_n),
        .bus   (bus_l)
    );

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] pix_val(input int w, input int r, input int c, input int fill);
        if (fill >= 0) return PW'(fill);
        return PW'(r * w + c + 1);
    endfunction

    // Zero-padded neighbourhood of (r,c) straight from the image definition.
    function automatic logic [WW-1:0] exp_win(input int h, input int w, input int r, input int c,
                                               input int fill);
        logic [WW-1:0] v;
        int rr, cc;
        v = '0;
        for (int i = 0; i < 9; i++) begin
            rr = r + i / 3 - 1;
            cc = c + i % 3 - 1;
            if (rr >= 0 && rr < h && cc >= 0 && cc < w)
                v[(8 - i) * PW +: PW] = pix_val(w, rr, cc, fill);
        end
        return v;
    endfunction

    task automatic push(input bit is_l, input logic [WW-1:0] win, input logic fd, input int at);
        exp_t e;
        e.win = win;
        e.fd  = fd;
        e.cyc = at;
        if (is_l) lq.push_back(e);
        else      sq.push_back(e);
    endtask

    task automatic drive(input bit is_l, input logic en, input logic [PW-1:0] pix);
        @(negedge clk);
        if (is_l) begin
            bus_l.in_en    = en;
            bus_l.pixel_in = pix;
        end else begin
            bus_s.in_en    = en;
            bus_s.pixel_in = pix;
        end
    endtask

    task automatic mon(input bit is_l, input logic vld, input logic fd, input logic [WW-1:0] win);
        exp_t e;
        bit   due;
        if (is_l) due = (lq.size() > 0) && (lq[0].cyc == cyc);
        else      due = (sq.size() > 0) && (sq[0].cyc == cyc);
        if (due) begin
            if (is_l) e = lq.pop_front();
            else      e = sq.pop_front();
            chk(is_l ? "l_valid" : "s_valid", WW'(vld), WW'(1'b1));
            chk(is_l ? "l_win" : "s_win", win, e.win);
            chk(is_l ? "l_frame_done" : "s_frame_done", WW'(fd), WW'(e.fd));
        end else begin
            chk(is_l ? "l_idle" : "s_idle", WW'({vld, fd}), '0);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (bus_s.win_valid) s_vld++;
        if (bus_s.frame_done) s_fd++;
        mon(1'b0, bus_s.win_valid, bus_s.frame_done, bus_s.win_out);
    end

    initial forever begin
        @(negedge clk);
        if (bus_l.win_valid) l_vld++;
        if (bus_l.frame_done) l_fd++;
        mon(1'b1, bus_l.win_valid, bus_l.frame_done, bus_l.win_out);
    end

    // Sends npix pixels; a complete frame also books the flush windows and spends
    // the flush cycles driving in_en=flush_en with junk that must be dropped.
    task automatic send_frame(input bit is_l, input int h, input int w, input int fill,
                              input int npix, input bit stall, input bit flush_en);
        int d;
        int j;
        d = 0;
        for (int k = 0; k < npix; k++) begin
            drive(is_l, 1'b1, pix_val(w, k / w, k % w, fill));
            d = cyc;
            if (k >= w + 1) begin
                j = k - w - 1;
                push(is_l, exp_win(h, w, j / w, j % w, fill), 1'b0, d + 1);
            end
            if (stall && k != npix - 1) drive(is_l, 1'b0, 8'h5A);
        end
        if (npix == h * w) begin
            for (int i = 0; i <= w; i++) begin
                j = h * w - w - 1 + i;
                push(is_l, exp_win(h, w, j / w, j % w, fill), (i == w), d + 2 + i);
            end
            for (int i = 0; i <= w; i++) drive(is_l, flush_en, 8'hA5);
        end
    endtask

    task automatic idle(input bit is_l, input int n);
        for (int i = 0; i < n; i++) drive(is_l, 1'b0, 8'h00);
    endtask

    initial begin
        rst_s_n        = 1'b0;
        rst_l_n        = 1'b0;
        bus_s.in_en    = 1'b0;
        bus_s.pixel_in = '0;
        bus_l.in_en    = 1'b0;
        bus_l.pixel_in = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_win", bus_s.win_out, '0);
        chk("rst_s_flags", WW'({bus_s.win_valid, bus_s.frame_done}), '0);
        chk("rst_l_win", bus_l.win_out, '0);
        chk("rst_l_flags", WW'({bus_l.win_valid, bus_l.frame_done}), '0);
        @(negedge clk);
        rst_s_n = 1'b1;
        rst_l_n = 1'b1;

        // 4x4 ramp frame, continuous input
        s_vld = 0;
        s_fd  = 0;
        send_frame(1'b0, SH, SW, -1, SH * SW, 1'b0, 1'b0);
        idle(1'b0, 4);
        chk("s_pulses", WW'(s_vld), WW'(SH * SW));
        chk("s_frames", WW'(s_fd), WW'(1));

        // Same frame with in_en alternating
        s_vld = 0;
        send_frame(1'b0, SH, SW, -1, SH * SW, 1'b1, 1'b0);
        idle(1'b0, 4);
        chk("s_stall_pulses", WW'(s_vld), WW'(SH * SW));

        // Reset after 9 pixels, then a clean frame
        send_frame(1'b0, SH, SW, -1, 9, 1'b0, 1'b0);
        idle(1'b0, 2);
        chk("s_q_before_rst", WW'(sq.size()), '0);
        @(negedge clk);
        rst_s_n = 1'b0;
        #1;
        chk("s_midrst_win", bus_s.win_out, '0);
        chk("s_midrst_flags", WW'({bus_s.win_valid, bus_s.frame_done}), '0);
        @(negedge clk);
        rst_s_n = 1'b1;
        s_vld = 0;
        send_frame(1'b0, SH, SW, -1, SH * SW, 1'b0, 1'b0);
        idle(1'b0, 4);
        chk("s_after_rst_pulses", WW'(s_vld), WW'(SH * SW));

        // 128x128 constant frames back to back, in_en held high through flush
        l_vld = 0;
        l_fd  = 0;
        send_frame(1'b1, LH, LW, 100, LH * LW, 1'b0, 1'b1);
        send_frame(1'b1, LH, LW, 100, LH * LW, 1'b0, 1'b1);
        idle(1'b1, 4);

        for (int i = 0; i < 300 && (sq.size() > 0 || lq.size() > 0); i++) @(negedge clk);
        chk("drain", WW'(sq.size() + lq.size()), '0);
        chk("l_pulses", WW'(l_vld), WW'(2 * LH * LW));
        chk("l_frames", WW'(l_fd), WW'(2));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
